// File: rtl/stream_arb_pkg.sv
// Shared types and CSR address map for the stream packet arbiter.
package stream_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_t;

  localparam logic [3:0] CSR_MASK     = 4'd0;
  localparam logic [3:0] CSR_STATUS   = 4'd1;
  localparam logic [3:0] CSR_CNT_BASE = 4'd2;
  localparam logic [3:0] CSR_CNT_CLR  = 4'd15;

  localparam int MAX_INPUTS = 8;

endpackage

// File: rtl/stream_packet_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first requester above last_grant, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int GW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last_grant,
  output logic [GW-1:0] grant,
  output logic          any
);

  // Walk the N positions starting just after last_grant; first hit wins.
  always_comb begin
    int  idx;
    logic take;
    grant = {GW{1'b0}};
    any   = 1'b0;
    idx   = 0;
    take  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx   = (int'(last_grant) + k) % N;
      take  = req[idx] & ~any;
      grant = take ? GW'(idx) : grant;
      any   = any | req[idx];
    end
  end

endmodule

// File: rtl/stream_packet_arbiter.sv
// Packet-granular round-robin Avalon-ST arbiter with a small CSR block.
// Optional per-source packet counters are built when ARB_STATS_EN is defined.
module stream_packet_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_BYTES = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_INPUTS*DATA_BYTES*8-1:0]      in_data,
  input  logic [NUM_INPUTS*$clog2(DATA_BYTES)-1:0] in_empty,
  input  logic [NUM_INPUTS-1:0]                   in_valid,
  input  logic [NUM_INPUTS-1:0]                   in_startofpacket,
  input  logic [NUM_INPUTS-1:0]                   in_endofpacket,
  output logic [NUM_INPUTS-1:0]                   in_ready,
  output logic [DATA_BYTES*8-1:0]                 out_data,
  output logic [$clog2(DATA_BYTES)-1:0]           out_empty,
  output logic                                    out_valid,
  output logic                                    out_startofpacket,
  output logic                                    out_endofpacket,
  input  logic                                    out_ready,
  input  logic [3:0]                              csr_address,
  input  logic                                    csr_read,
  input  logic                                    csr_write,
  input  logic [31:0]                             csr_writedata,
  output logic [31:0]                             csr_readdata,
  output logic                                    csr_readdatavalid
);

  localparam int DW = DATA_BYTES * 8;
  localparam int EW = $clog2(DATA_BYTES);
  localparam int GW = $clog2(NUM_INPUTS);

  arb_state_t            state_r, next_state_s;
  logic [GW-1:0]         grant_r, grant_next_s;
  logic [GW-1:0]         last_grant_r, last_grant_next_s;
  logic [NUM_INPUTS-1:0] mask_r;
  logic [NUM_INPUTS-1:0] req_s;
  logic [GW-1:0]         pick_s;
  logic                  any_s;
  logic                  accept_s;
  logic                  eop_accept_s;
  logic                  csr_wr_s;
  logic [31:0]           status_s;
  logic [31:0]           rd_mux_s;
  logic [31:0]           cnt_rd_s;
  logic [31:0]           readdata_r;
  logic                  readdatavalid_r;
  logic                  unused_wdata_s;

  assign req_s          = in_valid & mask_r;
  assign csr_wr_s       = csr_write & ~csr_read;
  assign unused_wdata_s = ^csr_writedata;

  rr_pick #(.N(NUM_INPUTS), .GW(GW)) u_pick (
    .req        (req_s),
    .last_grant (last_grant_r),
    .grant      (pick_s),
    .any        (any_s)
  );

  // Next-state logic and the combinational stream mux for the granted source.
  always_comb begin
    next_state_s      = state_r;
    grant_next_s      = grant_r;
    last_grant_next_s = last_grant_r;
    in_ready          = {NUM_INPUTS{1'b0}};
    out_data          = {DW{1'b0}};
    out_empty         = {EW{1'b0}};
    out_valid         = 1'b0;
    out_startofpacket = 1'b0;
    out_endofpacket   = 1'b0;
    accept_s          = 1'b0;
    eop_accept_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          grant_next_s = pick_s;
          next_state_s = PASS;
        end else begin
          next_state_s = IDLE;
        end
      end
      PASS: begin
        out_data          = in_data[int'(grant_r)*DW +: DW];
        out_empty         = in_empty[int'(grant_r)*EW +: EW];
        out_valid         = in_valid[grant_r];
        out_startofpacket = in_startofpacket[grant_r];
        out_endofpacket   = in_endofpacket[grant_r];
        in_ready[grant_r] = out_ready;
        accept_s          = in_valid[grant_r] & out_ready;
        eop_accept_s      = accept_s & in_endofpacket[grant_r];
        if (eop_accept_s) begin
          last_grant_next_s = grant_r;
          next_state_s      = IDLE;
        end else begin
          next_state_s = PASS;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Arbiter state registers; last_grant starts at the top so source 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      grant_r      <= {GW{1'b0}};
      last_grant_r <= GW'(NUM_INPUTS - 1);
    end else begin
      state_r      <= next_state_s;
      grant_r      <= grant_next_s;
      last_grant_r <= last_grant_next_s;
    end
  end

  // CSR read mux: status fields are zero-extended into 3-bit slots.
  always_comb begin
    status_s              = 32'h0;
    rd_mux_s              = 32'h0;
    status_s[0]           = (state_r == PASS);
    status_s[8 +: GW]     = grant_r;
    status_s[16 +: GW]    = last_grant_r;
    case (csr_address)
      CSR_MASK:   rd_mux_s[NUM_INPUTS-1:0] = mask_r;
      CSR_STATUS: rd_mux_s = status_s;
      default:    rd_mux_s = cnt_rd_s;
    endcase
  end

  // Mask register and registered read port; a simultaneous read drops the write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_r          <= {NUM_INPUTS{1'b1}};
      readdata_r      <= 32'h0;
      readdatavalid_r <= 1'b0;
    end else begin
      readdatavalid_r <= csr_read;
      readdata_r      <= csr_read ? rd_mux_s : readdata_r;
      if (csr_wr_s && (csr_address == CSR_MASK)) begin
        mask_r <= csr_writedata[NUM_INPUTS-1:0];
      end
    end
  end

  assign csr_readdata      = readdata_r;
  assign csr_readdatavalid = readdatavalid_r;

`ifdef ARB_STATS_EN
  logic [31:0] cnt_r [NUM_INPUTS];
  logic        clr_s;

  assign clr_s = csr_wr_s && (csr_address == CSR_CNT_CLR);

  // Counter read select for addresses CSR_CNT_BASE .. CSR_CNT_BASE+NUM_INPUTS-1.
  always_comb begin
    cnt_rd_s = 32'h0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (csr_address == (CSR_CNT_BASE + 4'(i))) begin
        cnt_rd_s = cnt_r[i];
      end else begin
        cnt_rd_s = cnt_rd_s;
      end
    end
  end

  // Per-source packet counters; a clear outranks a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_INPUTS; i++) cnt_r[i] <= 32'h0;
    end else if (clr_s) begin
      for (int i = 0; i < NUM_INPUTS; i++) cnt_r[i] <= 32'h0;
    end else if (eop_accept_s) begin
      cnt_r[grant_r] <= cnt_r[grant_r] + 32'd1;
    end
  end
`else
  assign cnt_rd_s = 32'h0;
`endif

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Self-checking bench: CSR vector table, scoreboarded packet streams, corner sequences.
module tb_stream_packet_arbiter;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
  } beat_t;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [3:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } csr_vec_t;

  logic         clk;
  logic         reset;
  logic [255:0] in_data;
  logic [11:0]  in_empty;
  logic [3:0]   in_valid;
  logic [3:0]   in_startofpacket;
  logic [3:0]   in_endofpacket;
  logic [3:0]   in_ready;
  logic [63:0]  out_data;
  logic [2:0]   out_empty;
  logic         out_valid;
  logic         out_startofpacket;
  logic         out_endofpacket;
  logic         out_ready;
  logic [3:0]   csr_address;
  logic         csr_read;
  logic         csr_write;
  logic [31:0]  csr_writedata;
  logic [31:0]  csr_readdata;
  logic         csr_readdatavalid;

  beat_t    src_q [4][$];
  beat_t    exp_q [$];
  int       log_src [$];
  int       log_cyc [$];
  logic [3:0] acc;
  logic [3:0] gap;
  int       cyc;
  int       checks;
  int       errors;
  int       ready_viol;
  csr_vec_t tbl [12];

  stream_packet_arbiter #(.NUM_INPUTS(4), .DATA_BYTES(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_data           (in_data),
    .in_empty          (in_empty),
    .in_valid          (in_valid),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_ready          (in_ready),
    .out_data          (out_data),
    .out_empty         (out_empty),
    .out_valid         (out_valid),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_ready         (out_ready),
    .csr_address       (csr_address),
    .csr_read          (csr_read),
    .csr_write         (csr_write),
    .csr_writedata     (csr_writedata),
    .csr_readdata      (csr_readdata),
    .csr_readdatavalid (csr_readdatavalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_data(input int src, input int pkt, input int beat);
    return {8'(src), 8'(pkt), 8'(beat), 8'hA5, 32'(src * 7919 + pkt * 31 + beat)};
  endfunction

  task automatic add_pkt(input int src, input int pkt, input int n, input int nexp);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data  = mk_data(src, pkt, k);
      b.sop   = (k == 0);
      b.eop   = (k == n - 1);
      b.empty = 3'((src + k) % 8);
      src_q[src].push_back(b);
      if (k < nexp) exp_q.push_back(b);
    end
  endtask

  // Source driver: retire beats accepted at the last edge, present the next head.
  initial begin
    beat_t dummy;
    in_valid = 4'b0; in_data = 256'h0; in_empty = 12'h0;
    in_startofpacket = 4'b0; in_endofpacket = 4'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && src_q[i].size() > 0) dummy = src_q[i].pop_front();
        if (src_q[i].size() > 0 && !gap[i]) begin
          in_valid[i]           = 1'b1;
          in_data[i*64 +: 64]   = src_q[i][0].data;
          in_empty[i*3 +: 3]    = src_q[i][0].empty;
          in_startofpacket[i]   = src_q[i][0].sop;
          in_endofpacket[i]     = src_q[i][0].eop;
        end else begin
          in_valid[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: record handshakes, compare accepted beats against the scoreboard.
  initial begin
    beat_t e;
    beat_t a;
    logic [3:0] rdy_exp;
    acc = 4'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) acc[i] = in_valid[i] & in_ready[i];
      if (out_valid) begin
        rdy_exp = out_ready ? (4'b0001 << out_data[63:56]) : 4'b0000;
        if (in_ready !== rdy_exp) ready_viol = ready_viol + 1;
      end
      if (out_valid && out_ready) begin
        a = {out_data, out_startofpacket, out_endofpacket, out_empty};
        log_src.push_back(int'(out_data[63:56]));
        log_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 128'(a), 128'h0);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 128'(a), 128'(e));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csr_cycle(input logic wr, input logic rd, input logic [3:0] addr, input logic [31:0] wd);
    csr_write = wr; csr_read = rd; csr_address = addr; csr_writedata = wd;
    @(posedge clk);
    #1;
    csr_write = 1'b0; csr_read = 1'b0;
  endtask

  task automatic csr_rd(input string name, input logic [3:0] addr, input logic [31:0] exp);
    csr_cycle(1'b0, 1'b1, addr, 32'h0);
    chk({name, "_valid"}, 128'(csr_readdatavalid), 128'(1'b1));
    chk(name, 128'(csr_readdata), 128'(exp));
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (log_src.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(name, 128'(log_src.size() >= n), 128'(1'b1));
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(name, 128'(exp_q.size()), 128'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) src_q[i].delete();
    gap = 4'b0;
    exp_q.delete();
    idle(2);
    reset = 1'b0;
    log_src.delete();
    log_cyc.delete();
  endtask

  initial begin
    int n;
    int gaps1 [5];
    int srcs1 [6];
    checks = 0; errors = 0; ready_viol = 0;
    gap = 4'b0; out_ready = 1'b1; reset = 1'b1;
    csr_address = 4'd0; csr_read = 1'b0; csr_write = 1'b0; csr_writedata = 32'h0;
    gaps1 = '{1, 1, 2, 1, 1};
    srcs1 = '{0, 0, 0, 2, 2, 2};

    tbl[0]  = '{1'b0, 1'b1, 4'd0,  32'h0,      32'h0000_000F};
    tbl[1]  = '{1'b0, 1'b1, 4'd1,  32'h0,      32'h0003_0000};
    tbl[2]  = '{1'b1, 1'b0, 4'd0,  32'h0000_003A, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 4'd0,  32'h0,      32'h0000_000A};
    tbl[4]  = '{1'b1, 1'b1, 4'd0,  32'h0000_0001, 32'h0000_000A};
    tbl[5]  = '{1'b0, 1'b1, 4'd0,  32'h0,      32'h0000_000A};
    tbl[6]  = '{1'b1, 1'b0, 4'd7,  32'h0000_FFFF, 32'h0};
    tbl[7]  = '{1'b0, 1'b1, 4'd7,  32'h0,      32'h0};
    tbl[8]  = '{1'b0, 1'b1, 4'd15, 32'h0,      32'h0};
    tbl[9]  = '{1'b1, 1'b0, 4'd0,  32'h0000_000F, 32'h0};
    tbl[10] = '{1'b0, 1'b1, 4'd0,  32'h0,      32'h0000_000F};
    tbl[11] = '{1'b0, 1'b0, 4'd0,  32'h0,      32'h0};

    idle(3);
    reset = 1'b0;
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_in_ready", 128'(in_ready), 128'(4'b0));
    chk("rst_rdvalid", 128'(csr_readdatavalid), 128'(1'b0));
    chk("rst_rdata", 128'(csr_readdata), 128'(32'h0));

    for (int i = 0; i < 12; i++) begin
      csr_cycle(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wd);
      chk($sformatf("csr_vec%0d_valid", i), 128'(csr_readdatavalid), 128'(tbl[i].rd));
      if (tbl[i].rd) chk($sformatf("csr_vec%0d_data", i), 128'(csr_readdata), 128'(tbl[i].exp));
    end

    // Two 3-beat packets: source 0 first, one idle cycle, then source 2.
    do_reset();
    add_pkt(0, 1, 3, 3);
    add_pkt(2, 2, 3, 3);
    wait_drain(60, "t1_drain");
    chk("t1_count", 128'(log_src.size()), 128'(6));
    if (log_src.size() == 6) begin
      for (int j = 0; j < 6; j++) chk($sformatf("t1_src%0d", j), 128'(log_src[j]), 128'(srcs1[j]));
      for (int j = 0; j < 5; j++) chk($sformatf("t1_gap%0d", j), 128'(log_cyc[j+1] - log_cyc[j]), 128'(gaps1[j]));
    end

    // Continuous single-beat packets from all sources: strict rotation, beat then idle.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 4; s++) add_pkt(s, 10 + r, 1, 1);
    wait_drain(100, "t2_drain");
    chk("t2_count", 128'(log_src.size()), 128'(8));
    if (log_src.size() == 8) begin
      for (int j = 0; j < 8; j++) chk($sformatf("t2_src%0d", j), 128'(log_src[j]), 128'(j % 4));
      for (int j = 1; j < 8; j++) chk($sformatf("t2_gap%0d", j), 128'(log_cyc[j] - log_cyc[j-1]), 128'(2));
    end

    // Mask written mid-packet: source 1 completes, then only sources 2 and 0 are served.
    do_reset();
    add_pkt(1, 30, 4, 4);
    wait_log(2, 40, "t3_start");
    csr_cycle(1'b1, 1'b0, 4'd0, 32'h0000_0005);
    add_pkt(2, 32, 1, 1);
    add_pkt(0, 31, 1, 1);
    add_pkt(3, 33, 1, 0);
    add_pkt(1, 34, 1, 0);
    wait_drain(60, "t3_drain");
    idle(12);
    chk("t3_count", 128'(log_src.size()), 128'(6));
    chk("t3_in_ready_idle", 128'(in_ready), 128'(4'b0));
    csr_rd("t3_mask", 4'd0, 32'h0000_0005);
    for (int i = 0; i < 4; i++) src_q[i].delete();
    idle(2);
    csr_cycle(1'b1, 1'b0, 4'd0, 32'h0000_000F);

    // Backpressure and a source gap mid-packet: grant held, nothing lost or duplicated.
    do_reset();
    add_pkt(0, 40, 5, 5);
    wait_log(1, 40, "t4_first");
    out_ready = 1'b0;
    n = log_src.size();
    csr_rd("t4_status_stall", 4'd1, 32'h0003_0001);
    idle(2);
    chk("t4_no_beat_stalled", 128'(log_src.size()), 128'(n));
    out_ready = 1'b1;
    wait_log(n + 1, 40, "t4_resume");
    gap[0] = 1'b1;
    idle(2);
    n = log_src.size();
    csr_rd("t4_status_gap", 4'd1, 32'h0003_0001);
    chk("t4_no_beat_gap", 128'(log_src.size()), 128'(n));
    gap[0] = 1'b0;
    wait_drain(60, "t4_drain");
    chk("t4_count", 128'(log_src.size()), 128'(5));
    idle(2);
    csr_rd("t4_status_done", 4'd1, 32'h0000_0000);

    // Reset during beat 2 of a 4-beat packet aborts it; source 0 regains top priority.
    do_reset();
    add_pkt(2, 50, 4, 1);
    wait_log(1, 40, "t5_first");
    reset = 1'b1;
    for (int i = 0; i < 4; i++) src_q[i].delete();
    @(negedge clk);
    chk("t5_out_valid", 128'(out_valid), 128'(1'b0));
    chk("t5_in_ready", 128'(in_ready), 128'(4'b0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("t5_beats", 128'(log_src.size()), 128'(1));
    csr_rd("t5_status", 4'd1, 32'h0003_0000);
    add_pkt(0, 52, 1, 1);
    add_pkt(3, 51, 1, 1);
    wait_drain(40, "t5_drain");

`ifdef ARB_STATS_EN
    // Packet counters: five packets from source 3, then a clear.
    do_reset();
    for (int k = 0; k < 5; k++) add_pkt(3, 60 + k, 2, 2);
    wait_drain(200, "t6_drain");
    idle(2);
    csr_rd("t6_cnt3", 4'd5, 32'd5);
    csr_rd("t6_cnt0", 4'd2, 32'd0);
    csr_cycle(1'b1, 1'b0, 4'd15, 32'h0);
    csr_rd("t6_cnt3_clr", 4'd5, 32'd0);
`endif

    chk("ready_onehot", 128'(ready_viol), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_packet_arbiter.md
Name: stream_packet_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one Avalon-ST sink, normally the endian swapper's stream_in, between NUM_INPUTS Avalon-ST sources.
- Once a source is granted, it holds the grant from its first accepted beat until its endofpacket beat is accepted, so packets never interleave.
- A small Avalon-MM CSR bus masks sources on and off and reports arbiter state.
- The block sits directly upstream of the swapper in the streaming datapath.

Parameters:
- NUM_INPUTS, 4, number of source streams, 2..8.
- DATA_BYTES, 8, bytes per beat; must match the downstream sink.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  NUM_INPUTS*DATA_BYTES*8  packed source data; source i occupies slice i.
- in_empty  in  NUM_INPUTS*$clog2(DATA_BYTES)  packed empty fields.
- in_valid  in  NUM_INPUTS  per-source valid.
- in_startofpacket  in  NUM_INPUTS  per-source start-of-packet.
- in_endofpacket  in  NUM_INPUTS  per-source end-of-packet.
- in_ready  out  NUM_INPUTS  per-source ready.
- out_data  out  DATA_BYTES*8  muxed data.
- out_empty  out  $clog2(DATA_BYTES)  muxed empty.
- out_valid  out  1  muxed valid.
- out_startofpacket  out  1  muxed start-of-packet.
- out_endofpacket  out  1  muxed end-of-packet.
- out_ready  in  1  sink ready; readyLatency 0.
- csr_address  in  4  word address.
- csr_read  in  1  read strobe.
- csr_write  in  1  write strobe.
- csr_writedata  in  32  write data.
- csr_readdata  out  32  read data; readLatency fixed at 1.
- csr_readdatavalid  out  1  read data valid.

Behaviour:
- FSM states: IDLE, PASS.
  - Reset puts the FSM in IDLE and sets last_grant = NUM_INPUTS-1, so source 0 has top priority after reset.
  - enable_mask resets to all ones.
  - Registered csr_readdata resets to 0; csr_readdatavalid resets to 0.
- IDLE:
  - out_valid = 0 and in_ready = 0.
  - req = in_valid & enable_mask.
  - If req != 0, the first set bit searching upward from last_grant+1 (wrapping modulo NUM_INPUTS) is registered as grant, and the FSM moves to PASS on the next edge.
  - Arbitration costs exactly 1 idle cycle per packet.
- PASS:
  - The out_* fields combinationally mirror source grant.
  - in_ready[grant] = out_ready; every other in_ready bit is 0.
  - A beat is accepted when in_valid[grant] & out_ready.
  - When an accepted beat has endofpacket set: last_grant <= grant and the FSM returns to IDLE.
- Start-of-packet is not checked. Whichever beat is at the head of a granted source opens its burst.
- Single-beat packet (SOP and EOP on the same beat): accepted, then IDLE.
- Stalls: in_valid[grant] = 0 mid-packet keeps the grant. out_ready = 0 leaves all state unchanged.
- Mask writes take effect at the next IDLE arbitration only. A masked-off source mid-packet still completes its packet.
- Reset asserted mid-packet aborts the packet immediately; the downstream sink is responsible for recovery.
- CSR map:
  - Address 0: enable_mask, RW, bits NUM_INPUTS-1:0; upper bits read as 0.
  - Address 1: status, RO. Bit 0 = state (1 = PASS); bits 10:8 = grant; bits 18:16 = last_grant.
  - Other addresses read 0; writes to them are ignored.
- CSR timing:
  - csr_readdatavalid pulses exactly one cycle after csr_read.
  - csr_read and csr_write in the same cycle: the read wins and the write is dropped.
  - There is no waitrequest.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined: per-source 32-bit packet counters, incremented on each accepted EOP beat.
  - Source i's counter is readable at address 2+i.
  - Counters wrap 0xFFFFFFFF -> 0.
  - Any write to address 15 clears all counters. If the clear and an increment land in the same cycle, the clear wins.
- Undefined: no counters are built; addresses 2..15 read 0 and writes are ignored.

Decomposition:
- Package stream_arb_pkg holds:
  - typedef arb_state_t {IDLE, PASS};
  - CSR address constants CSR_MASK = 0, CSR_STATUS = 1, CSR_CNT_BASE = 2, CSR_CNT_CLR = 15;
  - MAX_INPUTS = 8.
- One sub-module, rr_pick: combinational round-robin priority encoder with inputs req, last_grant and outputs grant, any.

Test Plan:
- Reset, then sources 0 and 2 each present a 3-beat packet with out_ready = 1 -> source 0's packet comes out as 3 contiguous beats, then 1 idle cycle, then source 2's 3 beats. in_ready[2] stays 0 throughout source 0's packet.
- All 4 sources keep single-beat packets pending continuously -> grant order 0,1,2,3,0,... Each beat is followed by 1 idle cycle.
- Write enable_mask = 4'b0101 while source 1 is mid-packet -> source 1 finishes its packet; afterwards only sources 0 and 2 are granted. Reading address 0 returns 0x5 one cycle after the read.
- Toggle out_ready 1,0,1 and drop in_valid[grant] mid-packet -> no beat is lost or duplicated, the grant is held, and status bit 0 stays 1.
- Assert reset during beat 2 of a 4-beat packet -> next cycle out_valid = 0 and the FSM is in IDLE with source 0 at top priority.
- With ARB_STATS_EN defined, send 5 packets from source 3 -> address 5 reads 5. Write address 15 -> address 5 reads 0.
